// File: rtl/store_lane_formatter.sv
// store_lane_formatter
//   Store-path lane formatter between EX and data memory. Takes a big-endian
//   register-order store (SB/SH/SW) and registers a little-endian memory write
//   (word address, lane data, byte enables) behind a single-entry
//   valid/ready stage. Misaligned or illegal stores are still passed through
//   with misaligned=1, mem_be=0 and mem_wdata=0, and are tallied in a
//   saturating error counter.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               squash the held entry (blocks acceptance this cycle)
//   in_valid/in_ready   request handshake
//   in_addr/in_data     store byte address and register value
//   in_size             00 byte, 01 half, 10 word, 11 illegal
//   out_valid/out_ready memory-write handshake
//   mem_addr            word-aligned address
//   mem_wdata/mem_be    lane-formatted data and byte enables
//   misaligned          held entry is misaligned or illegal
//   err_count           saturating count of accepted misaligned/illegal stores
module store_lane_formatter #(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [31:0]          in_data,
  input  logic [1:0]           in_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  output logic                 misaligned,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [1:0]  off;
  logic        accept;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;
  logic        fmt_mis;

  assign off      = in_addr[1:0];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Register bytes are big-endian: the most significant stored byte lands
  // at the lowest memory offset.
  always_comb begin
    fmt_data = '0;
    fmt_be   = '0;
    fmt_mis  = 1'b0;
    case (in_size)
      2'b00: begin
        fmt_data = {24'h0, in_data[7:0]} << {off, 3'b000};
        fmt_be   = 4'b0001 << off;
      end
      2'b01: begin
        if (off[0]) begin
          fmt_mis = 1'b1;
        end else if (off[1]) begin
          fmt_data = {in_data[7:0], in_data[15:8], 16'h0};
          fmt_be   = 4'b1100;
        end else begin
          fmt_data = {16'h0, in_data[7:0], in_data[15:8]};
          fmt_be   = 4'b0011;
        end
      end
      2'b10: begin
        if (off != 2'b00) begin
          fmt_mis = 1'b1;
        end else begin
          fmt_data = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
          fmt_be   = 4'b1111;
        end
      end
      default: fmt_mis = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      misaligned <= 1'b0;
      err_count  <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        mem_addr   <= {in_addr[ADDR_W-1:2], 2'b00};
        mem_wdata  <= fmt_data;
        mem_be     <= fmt_be;
        misaligned <= fmt_mis;
        if (fmt_mis && (err_count != '1))
          err_count <= err_count + 1'b1;
      end else if (flush || out_ready) begin
        // Without an accept, either a flush or a completed drain empties
        // the stage; clearing when already empty is harmless.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_lane_formatter.sv
module tb_store_lane_formatter;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, misaligned;
  logic [31:0] in_addr, in_data, mem_addr, mem_wdata;
  logic [1:0]  in_size;
  logic [3:0]  mem_be;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic        ev;
  logic        known;
  logic [31:0] ea, ew;
  logic [3:0]  eb;
  logic        em;
  int          ee;

  store_lane_formatter #(.ADDR_W(32), .ERR_CNT_W(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misaligned(misaligned), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-byte view of a store: the N low register bytes, most significant
  // first, occupy offsets o..o+N-1; alignment requires o to be a multiple of N.
  function automatic void ref_fmt(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s, output logic [31:0] w,
                                  output logic [3:0] be, output logic mis);
    int unsigned n, o;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    o = a[1:0];
    w = '0;
    be = '0;
    if (n == 0) mis = 1'b1;
    else mis = (o % n) != 0;
    if (!mis)
      for (int unsigned i = 0; i < n; i++) begin
        w[8*(o+i) +: 8] = d[8*(n-1-i) +: 8];
        be[o+i] = 1'b1;
      end
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic ordy, input logic fl,
                       input logic rst);
    in_valid = v; in_addr = a; in_data = d; in_size = s;
    out_ready = ordy; flush = fl; reset = rst;
  endtask

  // One clock: check in_ready, advance the model at the edge, check outputs.
  task automatic cycle();
    logic        rdy, just_rst;
    logic [31:0] w;
    logic [3:0]  be;
    logic        mis;
    #2;
    rdy = !flush && (!ev || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    ref_fmt(in_addr, in_data, in_size, w, be, mis);
    @(posedge clock);
    just_rst = reset;
    if (reset) begin
      ev = 0; ea = 0; ew = 0; eb = 0; em = 0; ee = 0;
    end else if (in_valid && rdy) begin
      ev = 1; ea = {in_addr[31:2], 2'b00}; ew = w; eb = be; em = mis;
      if (mis && ee < 255) ee++;
    end else if (flush || out_ready) begin
      ev = 0;
    end
    #1;
    known = ev || just_rst;
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("err_count", {24'b0, err_count}, ee);
    if (known) begin
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ew);
      chk("mem_be", {28'b0, mem_be}, {28'b0, eb});
      chk("misaligned", {31'b0, misaligned}, {31'b0, em});
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
  } vec_t;

  vec_t vecs[8];

  initial begin
    ev = 0; known = 0; ea = 0; ew = 0; eb = 0; em = 0; ee = 0;
    vecs[0] = '{32'h1000, 32'h11223344, 2'b10, 32'h44332211, 4'b1111, 1'b0};
    vecs[1] = '{32'h2002, 32'hFFFFABCD, 2'b01, 32'hCDAB0000, 4'b1100, 1'b0};
    vecs[2] = '{32'h2001, 32'h0000005A, 2'b00, 32'h00005A00, 4'b0010, 1'b0};
    vecs[3] = '{32'h2003, 32'h123456C3, 2'b00, 32'hC3000000, 4'b1000, 1'b0};
    vecs[4] = '{32'h2000, 32'h0000BEEF, 2'b01, 32'h0000EFBE, 4'b0011, 1'b0};
    vecs[5] = '{32'h3001, 32'h11223344, 2'b10, 32'h00000000, 4'b0000, 1'b1};
    vecs[6] = '{32'h3000, 32'h11223344, 2'b11, 32'h00000000, 4'b0000, 1'b1};
    vecs[7] = '{32'h3003, 32'h00001234, 2'b01, 32'h00000000, 4'b0000, 1'b1};

    // Reset two cycles, then idle
    drive(0, 0, 0, 0, 1, 0, 1); cycle(); cycle();
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    chk("idle_valid", {31'b0, out_valid}, 0);
    chk("idle_be", {28'b0, mem_be}, 0);
    chk("idle_ready", {31'b0, in_ready}, 1);

    // Table-driven single transfers
    foreach (vecs[i]) begin
      drive(1, vecs[i].addr, vecs[i].data, vecs[i].size, 1, 0, 0);
      cycle();
      chk("tbl_addr", mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
      chk("tbl_wdata", mem_wdata, vecs[i].wdata);
      chk("tbl_be", {28'b0, mem_be}, {28'b0, vecs[i].be});
      chk("tbl_mis", {31'b0, misaligned}, {31'b0, vecs[i].mis});
    end
    chk("tbl_errcnt", {24'b0, err_count}, 3);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();

    // Backpressure: first word stalls, second request waits
    drive(1, 32'h40, 32'hDEADBEEF, 2'b10, 0, 0, 0); cycle();
    drive(1, 32'h44, 32'h00001234, 2'b01, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold", mem_wdata, 32'hEFBEADDE);
      chk("bp_ready", {31'b0, in_ready}, 0);
    end
    drive(1, 32'h44, 32'h00001234, 2'b01, 1, 0, 0); cycle();
    chk("bp_second", mem_wdata, 32'h00003412);
    chk("bp_nobubble", {31'b0, out_valid}, 1);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();

    // Saturation of the error counter
    for (int k = 0; k < 300; k++) begin
      drive(1, 32'h5001, $urandom, 2'b10, 1, 0, 0); cycle();
    end
    chk("err_sat", {24'b0, err_count}, 32'hFF);
    drive(0, 0, 0, 0, 1, 0, 0); cycle();

    // Flush while stalled, with a request presented
    drive(1, 32'h60, 32'hCAFEF00D, 2'b10, 0, 0, 0); cycle();
    drive(1, 32'h64, 32'h11111111, 2'b10, 0, 1, 0);
    #2; chk("flush_ready", {31'b0, in_ready}, 0);
    cycle();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_err", {24'b0, err_count}, 32'hFF);

    // Reset during a stall
    drive(1, 32'h70, 32'h01020304, 2'b10, 0, 0, 0); cycle();
    drive(1, 32'h74, 32'h05060708, 2'b10, 0, 0, 1); cycle();
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", {24'b0, err_count}, 0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/store_lane_formatter.md
Name: store_lane_formatter

Overview:
- Store-path counterpart of the fetch byte-reorder stage, sitting between EX and data memory.
- Converts a big-endian register-order store (SB/SH/SW) into little-endian memory byte lanes with byte enables. Memory byte offset k maps to bus bits [8k+7:8k].
- Registered single-entry pipeline stage with a valid/ready handshake, a flush input, and misalignment detection with a saturating error counter.

Parameters:
- ADDR_W, 32, address width in bits.
- ERR_CNT_W, 8, width of the saturating misalignment error counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash the held entry; synchronous.
- in_valid  in  1  a store request is presented.
- in_ready  out  1  the stage accepts the request this cycle.
- in_addr  in  ADDR_W  byte address of the store.
- in_data  in  32  register value; the LSBs hold the byte or half to be stored.
- in_size  in  2  store size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- out_valid  out  1  the registered memory write is valid.
- out_ready  in  1  the memory accepts the write.
- mem_addr  out  ADDR_W  word-aligned address: in_addr[ADDR_W-1:2] followed by 2'b00.
- mem_wdata  out  32  lane-formatted write data.
- mem_be  out  4  byte enables; bit k enables bits [8k+7:8k].
- misaligned  out  1  the held entry is a misaligned or illegal store.
- err_count  out  ERR_CNT_W  saturating count of accepted misaligned or illegal requests.

Behaviour:
- Reset (reset=1 at a clock edge): out_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misaligned=0, err_count=0. Reset overrides flush and accept.
- Handshake rules:
  - in_ready = !flush && (!out_valid || out_ready). This is combinational and gives full throughput with no bubble.
  - Accept = in_valid && in_ready. On accept, all outputs load on the next edge: latency is 1 cycle.
  - The output fields hold stable while out_valid && !out_ready.
  - out_valid clears after out_ready && out_valid unless a new accept happens in the same cycle.
- Flush: the next edge sets out_valid=0. Any input presented in that cycle is not accepted, because in_ready=0. The data fields may retain stale values. err_count is unchanged by flush.
- Lane formatting, with o = in_addr[1:0]:
  - Byte: lane o = in_data[7:0]; mem_be = one-hot bit o.
  - Half, o=0: lane0 = in_data[15:8], lane1 = in_data[7:0], mem_be=0011.
  - Half, o=2: lane2 = in_data[15:8], lane3 = in_data[7:0], mem_be=1100.
  - Word, o=0: mem_wdata = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]}, mem_be=1111.
  - Non-enabled lanes are driven 0.
- Misaligned and illegal requests:
  - Cases: half with o odd, word with o≠0, or size 11.
  - The entry is still accepted and presented, with misaligned=1, mem_be=0000 and mem_wdata=0.
  - err_count increments by 1 on that accept and saturates at all-ones.
- Simultaneous events:
  - Accept while the downstream drains (out_valid && out_ready && in_valid): the new entry replaces the old one and out_valid stays 1.
  - Reset mid-stall: the held entry is discarded.

Test Plan:
- Reset for 2 cycles, then idle → out_valid=0, mem_be=0, err_count=0, in_ready=1.
- SW: addr=0x1000, data=0x11223344, size=10, out_ready=1 → next cycle mem_addr=0x1000, mem_wdata=0x44332211, mem_be=1111, misaligned=0.
- SH at addr=0x2002, data=0xXXXXABCD → mem_addr=0x2000, mem_wdata=0xCDAB0000, mem_be=1100. Then SB at addr=0x2001, data=0x5A → mem_wdata=0x00005A00, mem_be=0010.
- Backpressure:
  - Issue SW 0xDEADBEEF with out_ready=0 for 3 cycles while a second request waits → outputs hold at 0xEFBEADDE and in_ready=0.
  - Raise out_ready → back-to-back transfer, and the second request appears the next cycle with no bubble.
- Misaligned stores:
  - SW at addr=0x3001 → misaligned=1, mem_be=0000, err_count=1.
  - size=11 → err_count=2.
  - 300 consecutive misaligned stores → err_count saturates at 0xFF.
- Flush while a stalled entry is held, with in_valid=1 in the same cycle → next cycle out_valid=0, input not accepted. Assert reset during a stall → all outputs return to their reset values.
